// File: rtl/readout_pkg.sv
// Shared constants and arbiter state encoding for the column readout path.
package readout_pkg;

  localparam int NUM_SP     = 8;
  localparam int SP_AW      = 3;
  localparam int DW         = 26;
  localparam int COL_AW     = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int OUT_W      = COL_AW + SP_AW + DW;

  // Hit word layout: {TOA, FTOA, ToT, pix}
  localparam int TOA_MSB  = 25;
  localparam int FTOA_MSB = 16;
  localparam int TOT_MSB  = 11;
  localparam int PIX_MSB  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ACK   = 2'd2,
    ST_WAIT  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/readout_sync_fifo.sv
// Single-clock FIFO; the head is registered storage and reads as zero when empty.
module readout_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/column_readout_arbiter.sv
// Round-robin arbiter sharing one column bus among the super pixels; tags each
// granted word with pixel index and column address and queues it for the periphery.
module column_readout_arbiter
  import readout_pkg::*;
(
  input  logic                 clk_40MHz,
  input  logic                 rst,
  input  logic                 col_en,
  input  logic [COL_AW-1:0]    addr_col,
  input  logic [NUM_SP-1:0]    sp_req,
  input  logic [NUM_SP*DW-1:0] sp_data,
  output logic [NUM_SP-1:0]    sp_ack,
  output logic                 out_valid,
  output logic [OUT_W-1:0]     out_data,
  input  logic                 out_ready,
  output logic [15:0]          hit_cnt,
  output logic                 busy,
  output logic [1:0]           fsm_state
);

  arb_state_t       state;
  logic [SP_AW-1:0] rr_ptr;
  logic [SP_AW-1:0] gnt_idx;
  logic [SP_AW-1:0] pick;
  logic [DW-1:0]    hold;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;

  // Two-pass pick: lowest requester at or above rr_ptr, else lowest overall.
  always_comb begin
    pick = '0;
    for (int i = NUM_SP - 1; i >= 0; i--) begin
      if (sp_req[i]) pick = SP_AW'(i);
    end
    for (int i = NUM_SP - 1; i >= 0; i--) begin
      if (sp_req[i] && (i >= int'(rr_ptr))) pick = SP_AW'(i);
    end
  end

  // Winner and its data are captured on entry to GRANT, while the request is
  // known high, so a requester dropping during GRANT still gets a valid word.
  always_ff @(posedge clk_40MHz) begin
    if (rst) begin
      state   <= ST_IDLE;
      sp_ack  <= '0;
      gnt_idx <= '0;
      hold    <= '0;
      rr_ptr  <= '0;
      hit_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (col_en && (|sp_req) && !fifo_full) begin
            gnt_idx <= pick;
            hold    <= sp_data[pick*DW +: DW];
            state   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          sp_ack <= NUM_SP'(1) << gnt_idx;
          state  <= ST_ACK;
        end
        ST_ACK: begin
          sp_ack <= '0;
          rr_ptr <= SP_AW'(gnt_idx + 1'b1);
          if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
          state  <= ST_WAIT;
        end
        ST_WAIT: state <= ST_IDLE;
        default: begin
          sp_ack <= '0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Output handshake: a word transfers on any rising edge where out_valid and
  // out_ready are both high; out_data is stable while out_valid waits for ready.
  assign push = (state == ST_ACK);

  readout_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_40MHz),
    .rst   (rst),
    .push  (push),
    .din   ({addr_col, gnt_idx, hold}),
    .pop   (out_ready),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign busy      = (state != ST_IDLE) || !fifo_empty;
  assign fsm_state = state;

endmodule

// File: tb/tb_column_readout_arbiter.sv
// Bench for column_readout_arbiter: directed scenarios plus a randomized run
// scored against a round-robin model and an expected-word queue.
module tb_column_readout_arbiter;

  localparam int NUM_SP = 8;
  localparam int SP_AW  = 3;
  localparam int DW     = 26;
  localparam int COL_AW = 1;
  localparam int OW     = COL_AW + SP_AW + DW;

  logic                 clk_40MHz = 1'b0;
  logic                 rst;
  logic                 col_en;
  logic [COL_AW-1:0]    addr_col;
  logic [NUM_SP-1:0]    sp_req;
  logic [NUM_SP*DW-1:0] sp_data;
  logic [NUM_SP-1:0]    sp_ack;
  logic                 out_valid;
  logic [OW-1:0]        out_data;
  logic                 out_ready;
  logic [15:0]          hit_cnt;
  logic                 busy;
  logic [1:0]           fsm_state;

  int n_tests = 0;
  int n_fail  = 0;
  int rr      = 0;
  int total   = 0;
  logic [OW-1:0] exp_q[$];

  always #5 clk_40MHz = ~clk_40MHz;

  column_readout_arbiter dut (
    .clk_40MHz (clk_40MHz),
    .rst       (rst),
    .col_en    (col_en),
    .addr_col  (addr_col),
    .sp_req    (sp_req),
    .sp_data   (sp_data),
    .sp_ack    (sp_ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .hit_cnt   (hit_cnt),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  task automatic tick();
    @(posedge clk_40MHz);
    @(negedge clk_40MHz);
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    rr  = 0;
    exp_q.delete();
  endtask

  task automatic fill_data();
    for (int i = 0; i < NUM_SP; i++) sp_data[i*DW +: DW] = DW'($urandom);
  endtask

  function automatic logic [OW-1:0] word(input int idx);
    logic [SP_AW-1:0] ix;
    ix = idx[SP_AW-1:0];
    return {addr_col, ix, sp_data[idx*DW +: DW]};
  endfunction

  function automatic int rr_winner(input logic [NUM_SP-1:0] req, input int ptr);
    for (int k = 0; k < NUM_SP; k++) begin
      if (req[(ptr + k) % NUM_SP]) return (ptr + k) % NUM_SP;
    end
    return -1;
  endfunction

  function automatic int ack_index(input logic [NUM_SP-1:0] a);
    for (int i = 0; i < NUM_SP; i++) if (a[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    sp_req = 8'hFF; col_en = 1'b1; out_ready = 1'b0; addr_col = 1'b0;
    fill_data();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++; if (sp_ack !== 8'h00) begin n_fail++; $display("FAIL reset_ack c%0d: got %h want 00", c, sp_ack); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid c%0d: got %b want 0", c, out_valid); end
      n_tests++; if (hit_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_hit_cnt c%0d: got %0d want 0", c, hit_cnt); end
    end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    sp_req = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [OW-1:0] exp_w;
    apply_reset(2);
    addr_col = 1'b1; out_ready = 1'b0; col_en = 1'b1;
    sp_data[2*DW +: DW] = 26'h2A5_5A5;
    exp_w = {1'b1, 3'd2, 26'h2A5_5A5};
    sp_req = 8'h04;
    tick();
    n_tests++; if (sp_ack !== 8'h00) begin n_fail++; $display("FAIL single_ack_early: got %h want 00", sp_ack); end
    tick();
    n_tests++; if (sp_ack !== 8'h04) begin n_fail++; $display("FAIL single_ack: got %h want 04", sp_ack); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_early: got %b want 0", out_valid); end
    sp_req = 8'h00;
    tick();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_tests++; if (out_data !== exp_w) begin n_fail++; $display("FAIL single_data: got %h want %h", out_data, exp_w); end
    n_tests++; if (hit_cnt !== 16'd1) begin n_fail++; $display("FAIL single_hit_cnt: got %0d want 1", hit_cnt); end
    n_tests++; if (sp_ack !== 8'h00) begin n_fail++; $display("FAIL single_ack_one_cycle: got %h want 00", sp_ack); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_popped: got %b want 0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int acks[$];
    int ix;
    apply_reset(2);
    addr_col = 1'b0; col_en = 1'b1; out_ready = 1'b1;
    fill_data();
    sp_req = 8'hFF;
    for (int c = 0; c < 36; c++) begin
      tick();
      n_tests++; if ($countones(sp_ack) > 1) begin n_fail++; $display("FAIL rr_onehot c%0d: got %h want at most one bit", c, sp_ack); end
      if (sp_ack !== 8'h00) begin
        ix = ack_index(sp_ack);
        acks.push_back(ix);
        exp_q.push_back(word(ix));
      end
      if (out_valid === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rr_extra_word: got %h want none", out_data); end
        else begin
          if (out_data !== exp_q[0]) begin n_fail++; $display("FAIL rr_word: got %h want %h", out_data, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
    end
    n_tests++; if (acks.size() != 9) begin n_fail++; $display("FAIL rr_ack_count: got %0d want 9", acks.size()); end
    for (int k = 0; k < acks.size() && k < 9; k++) begin
      n_tests++; if (acks[k] != k % NUM_SP) begin n_fail++; $display("FAIL rr_order k%0d: got %0d want %0d", k, acks[k], k % NUM_SP); end
    end
    n_tests++; if (hit_cnt !== 16'd9) begin n_fail++; $display("FAIL rr_hit_cnt: got %0d want 9", hit_cnt); end
    sp_req = '0;
    repeat (8) tick();
  endtask

  task automatic test_fifo_full();
    int nacks;
    apply_reset(2);
    addr_col = 1'b1; col_en = 1'b1; out_ready = 1'b0;
    fill_data();
    sp_req = 8'hFF;
    nacks = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (sp_ack !== 8'h00) nacks++;
    end
    n_tests++; if (nacks != 4) begin n_fail++; $display("FAIL full_ack_count: got %0d want 4", nacks); end
    n_tests++; if (hit_cnt !== 16'd4) begin n_fail++; $display("FAIL full_hit_cnt: got %0d want 4", hit_cnt); end
    n_tests++; if (out_data !== word(0)) begin n_fail++; $display("FAIL full_head: got %h want %h", out_data, word(0)); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    nacks = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (sp_ack !== 8'h00) begin
        nacks++;
        n_tests++; if (sp_ack !== 8'h10) begin n_fail++; $display("FAIL full_refill_idx: got %h want 10", sp_ack); end
      end
    end
    n_tests++; if (nacks != 1) begin n_fail++; $display("FAIL full_refill_count: got %0d want 1", nacks); end
    n_tests++; if (hit_cnt !== 16'd5) begin n_fail++; $display("FAIL full_hit_cnt2: got %0d want 5", hit_cnt); end
    sp_req = '0;
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      n_tests++; if (out_valid !== 1'b1 || out_data !== word(k)) begin n_fail++; $display("FAIL full_drain k%0d: got %b/%h want 1/%h", k, out_valid, out_data, word(k)); end
      tick();
    end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_col_en();
    int nacks;
    apply_reset(2);
    addr_col = 1'b0; col_en = 1'b1; out_ready = 1'b1;
    fill_data();
    sp_req = 8'hE0;
    tick();
    col_en = 1'b0;
    tick();
    n_tests++; if (sp_ack !== 8'h20) begin n_fail++; $display("FAIL colen_ack5: got %h want 20", sp_ack); end
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_data !== word(5)) begin n_fail++; $display("FAIL colen_word5: got %b/%h want 1/%h", out_valid, out_data, word(5)); end
    n_tests++; if (hit_cnt !== 16'd1) begin n_fail++; $display("FAIL colen_hit_cnt: got %0d want 1", hit_cnt); end
    nacks = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (sp_ack !== 8'h00) nacks++;
    end
    n_tests++; if (nacks != 0) begin n_fail++; $display("FAIL colen_no_grant: got %0d want 0", nacks); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL colen_busy: got %b want 0", busy); end
    col_en = 1'b1;
    tick();
    tick();
    n_tests++; if (sp_ack !== 8'h40) begin n_fail++; $display("FAIL colen_resume: got %h want 40", sp_ack); end
    sp_req = '0;
    repeat (6) tick();
  endtask

  task automatic test_reset_mid();
    int nacks;
    int c;
    apply_reset(2);
    addr_col = 1'b1; col_en = 1'b1; out_ready = 1'b0;
    fill_data();
    sp_req = 8'hFF;
    nacks = 0;
    c = 0;
    while (nacks < 3 && c < 40) begin
      tick();
      if (sp_ack !== 8'h00) nacks++;
      c++;
    end
    n_tests++; if (nacks != 3) begin n_fail++; $display("FAIL midrst_reach_ack: got %0d acks want 3", nacks); end
    n_tests++; if (out_valid !== 1'b1 || hit_cnt !== 16'd2) begin n_fail++; $display("FAIL midrst_queued: got %b/%0d want 1/2", out_valid, hit_cnt); end
    rst = 1'b1;
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    n_tests++; if (hit_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_hit_cnt: got %0d want 0", hit_cnt); end
    n_tests++; if (sp_ack !== 8'h00) begin n_fail++; $display("FAIL midrst_ack: got %h want 00", sp_ack); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    rst = 1'b0;
    tick();
    tick();
    n_tests++; if (sp_ack !== 8'h01) begin n_fail++; $display("FAIL midrst_rr_restart: got %h want 01", sp_ack); end
    sp_req = '0;
    out_ready = 1'b1;
    repeat (8) tick();
    out_ready = 1'b0;
  endtask

  // One cycle of the randomized scenario. New requests appear only when an ack
  // is seen or when nothing is pending, so the pending set is stable between acks.
  task automatic rand_step(input bit allow_new);
    int w;
    w = -1;
    n_tests++; if (hit_cnt !== 16'(total)) begin n_fail++; $display("FAIL rand_hit_cnt: got %0d want %0d", hit_cnt, total); end
    if (sp_ack !== 8'h00) begin
      w = rr_winner(sp_req, rr);
      n_tests++;
      if (w < 0 || sp_ack !== (8'h01 << w)) begin
        n_fail++; $display("FAIL rand_grant: got %h want winner %0d of req %h ptr %0d", sp_ack, w, sp_req, rr);
      end
      if (w >= 0) begin
        exp_q.push_back(word(w));
        rr = (w + 1) % NUM_SP;
        sp_req[w] = 1'b0;
      end
      total++;
    end
    if (allow_new && (w >= 0 || sp_req == '0)) begin
      for (int i = 0; i < NUM_SP; i++) begin
        if (!sp_req[i] && i != w && $urandom_range(0, 3) == 0) begin
          sp_data[i*DW +: DW] = DW'($urandom);
          sp_req[i] = 1'b1;
        end
      end
    end
    out_ready = allow_new ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (out_ready && out_valid === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL rand_extra_word: got %h want none", out_data); end
      else begin
        if (out_data !== exp_q[0]) begin n_fail++; $display("FAIL rand_word: got %h want %h", out_data, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    tick();
  endtask

  task automatic test_random();
    int c;
    apply_reset(2);
    addr_col = COL_AW'($urandom_range(0, 1));
    col_en = 1'b1; out_ready = 1'b0; sp_req = '0;
    total = 0;
    for (int k = 0; k < 800; k++) rand_step(1'b1);
    c = 0;
    while (c < 400 && !(exp_q.size() == 0 && sp_req == '0 && busy === 1'b0)) begin
      rand_step(1'b0);
      c++;
    end
    n_tests++; if (exp_q.size() != 0 || sp_req != '0) begin n_fail++; $display("FAIL rand_drain: got %0d queued req %h want 0/00", exp_q.size(), sp_req); end
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rand_idle: got valid %b busy %b want 0/0", out_valid, busy); end
    n_tests++; if (hit_cnt !== 16'(total)) begin n_fail++; $display("FAIL rand_final_cnt: got %0d want %0d", hit_cnt, total); end
    n_tests++; if (total < 50) begin n_fail++; $display("FAIL rand_activity: got %0d words want at least 50", total); end
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; col_en = 1'b0; addr_col = '0; sp_req = '0; sp_data = '0; out_ready = 1'b0;
    @(negedge clk_40MHz);
    test_reset();
    test_single();
    test_round_robin();
    test_fifo_full();
    test_col_en();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
